// File: rtl/branch_predict_unit_if.sv
// -----------------------------------------------------------------------------
// branch_predict_unit_if
// Bundles the fetch-lookup and execute-resolve signals of the branch
// prediction unit.
//   master : drives f_pc and the ex_* resolve bus, receives the prediction,
//            the resolved-taken flag and the mispredict pulse.
//   slave  : the predictor itself.
// Optional macro BRANCH_STATS_EN adds the br_count / mis_count statistics.
// -----------------------------------------------------------------------------
interface branch_predict_unit_if #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 32
);
   logic [PC_W-1:0]  f_pc;
   logic             f_pred_taken;
   logic             ex_valid;
   logic [PC_W-1:0]  ex_pc;
   logic [2:0]       ex_type;
   logic             ex_zero;
   logic             ex_lt;
   logic             ex_pred_taken;
   logic             jump_flag;
   logic             mispredict;
`ifdef BRANCH_STATS_EN
   logic [CNT_W-1:0] br_count;
   logic [CNT_W-1:0] mis_count;
`endif

   modport master (
      output f_pc, ex_valid, ex_pc, ex_type, ex_zero, ex_lt, ex_pred_taken,
`ifdef BRANCH_STATS_EN
      input  br_count, mis_count,
`endif
      input  f_pred_taken, jump_flag, mispredict
   );

   modport slave (
      input  f_pc, ex_valid, ex_pc, ex_type, ex_zero, ex_lt, ex_pred_taken,
`ifdef BRANCH_STATS_EN
      output br_count, mis_count,
`endif
      output f_pred_taken, jump_flag, mispredict
   );
endinterface

// File: rtl/branch_predict_unit.sv
// -----------------------------------------------------------------------------
// branch_predict_unit
// Bimodal branch predictor: 2^IDX_W two-bit saturating counters indexed by
// pc[IDX_W+1:2]. Fetch gets a combinational prediction; execute resolves the
// branch, trains the table and raises a registered mispredict flush pulse.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus_io   : branch_predict_unit_if.slave (f_pc, f_pred_taken, ex_valid,
//              ex_pc, ex_type, ex_zero, ex_lt, ex_pred_taken, jump_flag,
//              mispredict, and br_count/mis_count when BRANCH_STATS_EN)
// Optional macro BRANCH_STATS_EN enables the branch / mispredict counters.
// -----------------------------------------------------------------------------
module branch_predict_unit #(
   parameter int PC_W  = 32,
   parameter int IDX_W = 6,
   parameter int CNT_W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   branch_predict_unit_if.slave  bus_io
);
   localparam int DEPTH = 1 << IDX_W;

   typedef enum logic [2:0] {
      T_NONE = 3'd0, T_BEQ = 3'd1, T_BNE = 3'd2, T_BLT = 3'd3,
      T_BGE  = 3'd4, T_BLTU = 3'd5, T_BGEU = 3'd6, T_JUMP = 3'd7
   } br_type_e;

   logic [1:0]       table_q [DEPTH];
   logic             jump_q;
   logic             mis_q;

   logic [IDX_W-1:0] f_idx;
   logic [IDX_W-1:0] ex_idx;
   logic             taken_d;
   logic             is_cond_d;
   logic             mis_cause_d;
   logic [1:0]       cnt_cur;
   logic [1:0]       cnt_d;

   assign f_idx  = bus_io.f_pc[IDX_W+1:2];
   assign ex_idx = bus_io.ex_pc[IDX_W+1:2];

   // Lookup sees the registered table only, so a same-cycle update to the
   // same index is not forwarded.
   assign bus_io.f_pred_taken = table_q[f_idx][1];

   always_comb begin
      taken_d   = 1'b0;
      is_cond_d = 1'b1;
      case (br_type_e'(bus_io.ex_type))
         T_BEQ:           taken_d = bus_io.ex_zero;
         T_BNE:           taken_d = ~bus_io.ex_zero;
         T_BLT, T_BLTU:   taken_d = bus_io.ex_lt;
         T_BGE, T_BGEU:   taken_d = ~bus_io.ex_lt;
         T_JUMP: begin
            taken_d   = 1'b1;
            is_cond_d = 1'b0;
         end
         default: begin
            taken_d   = 1'b0;
            is_cond_d = 1'b0;
         end
      endcase
   end

   // Type 0 is "not a control-flow instruction" and can never mispredict.
   assign mis_cause_d = bus_io.ex_valid && (bus_io.ex_type != 3'd0) &&
                        (taken_d != bus_io.ex_pred_taken);

   always_comb begin
      cnt_cur = table_q[ex_idx];
      cnt_d   = cnt_cur;
      if (taken_d) begin
         if (cnt_cur != 2'b11) cnt_d = cnt_cur + 2'd1;
      end else begin
         if (cnt_cur != 2'b00) cnt_d = cnt_cur - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) table_q[i] <= 2'b01;
         jump_q <= 1'b0;
         mis_q  <= 1'b0;
      end else begin
         if (bus_io.ex_valid && is_cond_d) table_q[ex_idx] <= cnt_d;
         jump_q <= bus_io.ex_valid & taken_d;
         mis_q  <= mis_cause_d;
      end
   end

   assign bus_io.jump_flag  = jump_q;
   assign bus_io.mispredict = mis_q;

`ifdef BRANCH_STATS_EN
   logic [CNT_W-1:0] br_cnt_q;
   logic [CNT_W-1:0] mis_cnt_q;

   // Counters wrap naturally at 2^CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_cnt_q  <= '0;
         mis_cnt_q <= '0;
      end else begin
         if (bus_io.ex_valid && (bus_io.ex_type != 3'd0)) br_cnt_q <= br_cnt_q + 1'b1;
         if (mis_cause_d) mis_cnt_q <= mis_cnt_q + 1'b1;
      end
   end

   assign bus_io.br_count  = br_cnt_q;
   assign bus_io.mis_count = mis_cnt_q;
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;
   localparam int PC_W  = 32;
   localparam int IDX_W = 6;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   branch_predict_unit_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

   branch_predict_unit #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: counter values as plain integers, statistics as ints.
   int   mtbl [64];
   int   m_br, m_mis;
   logic exp_pred, obs_pred, exp_jump, exp_mis;

   task automatic model_reset();
      for (int i = 0; i < 64; i++) mtbl[i] = 1;
      m_br  = 0;
      m_mis = 0;
   endtask

   // Drives one execute/fetch cycle, samples the lookup before the edge and
   // advances the reference model across the edge.
   task automatic apply(input bit v, input logic [31:0] pc, input logic [2:0] t,
                        input bit z, input bit lt, input bit pr, input logic [31:0] fpc);
      bit tk;
      int ix;
      @(negedge clk);
      bus.ex_valid = v; bus.ex_pc = pc; bus.ex_type = t;
      bus.ex_zero = z; bus.ex_lt = lt; bus.ex_pred_taken = pr; bus.f_pc = fpc;
      #1;
      obs_pred = bus.f_pred_taken;
      exp_pred = (mtbl[fpc[7:2]] >= 2);
      case (t)
         3'd1:       tk = z;
         3'd2:       tk = !z;
         3'd3, 3'd5: tk = lt;
         3'd4, 3'd6: tk = !lt;
         3'd7:       tk = 1'b1;
         default:    tk = 1'b0;
      endcase
      ix = int'(pc[7:2]);
      @(posedge clk);
      if (v && t >= 3'd1 && t <= 3'd6)
         mtbl[ix] = tk ? ((mtbl[ix] + 1 > 3) ? 3 : mtbl[ix] + 1)
                       : ((mtbl[ix] - 1 < 0) ? 0 : mtbl[ix] - 1);
      exp_jump = v && tk;
      exp_mis  = v && (t != 3'd0) && (tk != pr);
      if (v && t != 3'd0) m_br++;
      if (exp_mis) m_mis++;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.ex_valid = 1'b0;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.ex_valid = 0; bus.ex_pc = 0; bus.ex_type = 0; bus.ex_zero = 0;
      bus.ex_lt = 0; bus.ex_pred_taken = 0; bus.f_pc = 0;
      model_reset();
      repeat (2) @(posedge clk);
      for (int i = 0; i < 64; i++) begin
         bus.f_pc = 32'(i) << 2;
         #1;
         n_vec++;
         if (bus.f_pred_taken !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pred idx=%0d got=%b want=0", i, bus.f_pred_taken);
         end
      end
      n_vec++;
      if (bus.jump_flag !== 1'b0 || bus.mispredict !== 1'b0) begin
         n_err++;
         $display("FAIL reset_out jump=%b mis=%b want 0 0", bus.jump_flag, bus.mispredict);
      end
      @(negedge clk);
      rst_n = 1'b1;
      apply(0, 32'h0, 3'd0, 0, 0, 0, 32'h40);
      n_vec++;
      if (obs_pred !== 1'b0 || bus.jump_flag !== 1'b0 || bus.mispredict !== 1'b0) begin
         n_err++;
         $display("FAIL post_reset pred=%b jump=%b mis=%b want 0 0 0",
                  obs_pred, bus.jump_flag, bus.mispredict);
      end
      $display("test_reset done");
   endtask

   task automatic test_beq_train();
      logic want_pred [4];
      want_pred = '{1'b0, 1'b1, 1'b1, 1'b1};
      for (int k = 0; k < 3; k++) begin
         apply(1, 32'h40, 3'd1, 1, 0, 0, 32'h40);
         n_vec++;
         if (obs_pred !== want_pred[k] || bus.jump_flag !== 1'b1 || bus.mispredict !== 1'b1) begin
            n_err++;
            $display("FAIL beq_train k=%0d pred=%b jump=%b mis=%b want %b 1 1",
                     k, obs_pred, bus.jump_flag, bus.mispredict, want_pred[k]);
         end else $display("beq_train k=%0d pred=%b jump=1 mis=1", k, obs_pred);
      end
      apply(0, 32'h0, 3'd0, 0, 0, 0, 32'h40);
      n_vec++;
      if (obs_pred !== want_pred[3] || bus.jump_flag !== 1'b0 || bus.mispredict !== 1'b0) begin
         n_err++;
         $display("FAIL beq_idle pred=%b jump=%b mis=%b want 1 0 0",
                  obs_pred, bus.jump_flag, bus.mispredict);
      end
   endtask

   task automatic test_bge_bltu();
      apply(1, 32'h80, 3'd4, 0, 0, 1, 32'h80);
      n_vec++;
      if (bus.jump_flag !== 1'b1 || bus.mispredict !== 1'b0) begin
         n_err++;
         $display("FAIL bge jump=%b mis=%b want 1 0", bus.jump_flag, bus.mispredict);
      end else $display("bge jump=1 mis=0");
      apply(1, 32'h80, 3'd5, 0, 0, 1, 32'h80);
      n_vec++;
      if (obs_pred !== 1'b1 || bus.jump_flag !== 1'b0 || bus.mispredict !== 1'b1) begin
         n_err++;
         $display("FAIL bltu pred=%b jump=%b mis=%b want 1 0 1",
                  obs_pred, bus.jump_flag, bus.mispredict);
      end else $display("bltu pred=1 jump=0 mis=1");
      apply(0, 32'h80, 3'd1, 1, 1, 0, 32'h80);
      n_vec++;
      if (obs_pred !== 1'b0 || bus.jump_flag !== 1'b0 || bus.mispredict !== 1'b0) begin
         n_err++;
         $display("FAIL bltu_decr pred=%b jump=%b mis=%b want 0 0 0",
                  obs_pred, bus.jump_flag, bus.mispredict);
      end
   endtask

   task automatic test_jump_none();
      apply(1, 32'hC0, 3'd7, 0, 0, 0, 32'hC0);
      n_vec++;
      if (bus.jump_flag !== 1'b1 || bus.mispredict !== 1'b1) begin
         n_err++;
         $display("FAIL jal jump=%b mis=%b want 1 1", bus.jump_flag, bus.mispredict);
      end else $display("jal jump=1 mis=1");
      apply(1, 32'hC0, 3'd7, 0, 0, 0, 32'hC0);
      apply(1, 32'hC0, 3'd0, 1, 1, 1, 32'hC0);
      n_vec++;
      if (obs_pred !== 1'b0 || bus.jump_flag !== 1'b0 || bus.mispredict !== 1'b0) begin
         n_err++;
         $display("FAIL type0 pred=%b jump=%b mis=%b want 0 0 0",
                  obs_pred, bus.jump_flag, bus.mispredict);
      end else $display("type0 pred=0 jump=0 mis=0");
   endtask

   task automatic test_alias_reset();
      apply(1, 32'h004, 3'd1, 1, 0, 0, 32'h104);
      apply(0, 32'h0, 3'd0, 0, 0, 0, 32'h104);
      n_vec++;
      if (obs_pred !== 1'b1) begin
         n_err++;
         $display("FAIL alias pred=%b want 1", obs_pred);
      end else $display("alias 0x004->0x104 pred=1");
      // Reset lands between drive and the capturing edge of an update.
      @(negedge clk);
      bus.ex_valid = 1; bus.ex_pc = 32'h104; bus.ex_type = 3'd1;
      bus.ex_zero = 1; bus.ex_pred_taken = 0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if (bus.jump_flag !== 1'b0 || bus.mispredict !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_out jump=%b mis=%b want 0 0", bus.jump_flag, bus.mispredict);
      end
      for (int i = 0; i < 64; i++) begin
         bus.f_pc = 32'(i) << 2;
         #1;
         n_vec++;
         if (bus.f_pred_taken !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_pred idx=%0d got=%b want=0", i, bus.f_pred_taken);
         end
      end
      bus.ex_valid = 0;
      @(negedge clk);
      rst_n = 1'b1;
      apply(1, 32'h104, 3'd2, 0, 0, 0, 32'h004);
      apply(0, 32'h0, 3'd0, 0, 0, 0, 32'h004);
      n_vec++;
      if (obs_pred !== 1'b1) begin
         n_err++;
         $display("FAIL post_midreset pred=%b want 1", obs_pred);
      end else $display("post_midreset pred=1");
   endtask

   task automatic test_back_to_back();
      logic [31:0] pc, fpc;
      for (int k = 0; k < 400; k++) begin
         pc  = $urandom & 32'h13C;
         fpc = ($urandom_range(0, 1) == 0) ? pc : ($urandom & 32'h13C);
         apply($urandom_range(0, 3) != 0, pc, 3'($urandom_range(0, 7)),
               1'($urandom), 1'($urandom), 1'($urandom), fpc);
         n_vec++;
         if (obs_pred !== exp_pred || bus.jump_flag !== exp_jump || bus.mispredict !== exp_mis) begin
            n_err++;
            $display("FAIL rand k=%0d pc=%h pred=%b/%b jump=%b/%b mis=%b/%b (got/want)",
                     k, pc, obs_pred, exp_pred, bus.jump_flag, exp_jump,
                     bus.mispredict, exp_mis);
         end
`ifdef BRANCH_STATS_EN
         n_vec++;
         if (bus.br_count !== 4'(m_br) || bus.mis_count !== 4'(m_mis)) begin
            n_err++;
            $display("FAIL rand_stats k=%0d br=%0d/%0d mis=%0d/%0d (got/want)",
                     k, bus.br_count, 4'(m_br), bus.mis_count, 4'(m_mis));
         end
`endif
      end
      $display("test_back_to_back done");
   endtask

`ifdef BRANCH_STATS_EN
   task automatic test_stats();
      do_reset();
      for (int k = 0; k < 17; k++)
         apply(1, 32'h200, 3'd7, 0, 0, (k < 15), 32'h0);
      apply(0, 32'h0, 3'd0, 0, 0, 0, 32'h0);
      n_vec++;
      if (bus.br_count !== 4'd1 || bus.mis_count !== 4'd2) begin
         n_err++;
         $display("FAIL stats br=%0d mis=%0d want 1 2", bus.br_count, bus.mis_count);
      end else $display("stats br=1 mis=2");
   endtask
`endif

   initial begin
      test_reset();
      test_beq_train();
      test_bge_bltu();
      test_jump_none();
      test_alias_reset();
      test_back_to_back();
`ifdef BRANCH_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
